// File: rtl/me_pkg.sv
// Shared constants and state encoding for the motion-estimation search controller,
// its datapath and the bench.
package me_pkg;

  localparam int ME_MACRO_DIM  = 16;
  localparam int ME_SEARCH_DIM = 48;
  localparam int ME_SAD_W      = 16;
  localparam int ME_ADDR_W     = 6;
  localparam int ME_MV_W       = 6;

  localparam int NSTRIP = ME_SEARCH_DIM / ME_MACRO_DIM;
  localparam int NCX    = ME_SEARCH_DIM - ME_MACRO_DIM + 1;
  localparam int NCAND  = NCX * NCX;
  localparam int R      = (ME_SEARCH_DIM - ME_MACRO_DIM) / 2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD_CUR = 3'd1,
    ST_SEARCH   = 3'd2,
    ST_DRAIN    = 3'd3,
    ST_DONE     = 3'd4
  } me_state_t;

endpackage

// File: rtl/me_best_tracker.sv
// Counts candidate SADs in raster order and keeps the strict running minimum
// together with its signed motion vector.
module me_best_tracker
  import me_pkg::*;
#(
  parameter int SAD_W  = ME_SAD_W,
  parameter int MV_W   = ME_MV_W,
  parameter int CAND_X = NCX,
  parameter int RANGE  = R
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             en,
  input  logic [SAD_W-1:0] sad_in,
  input  logic             sad_valid,
  output logic             done_cnt,
  output logic [SAD_W-1:0] min_sad,
  output logic [MV_W-1:0]  mv_x,
  output logic [MV_W-1:0]  mv_y
);

  localparam int CAND_TOTAL = CAND_X * CAND_X;
  localparam int CNT_W      = $clog2(CAND_TOTAL + 1);
  localparam int POS_W      = $clog2(CAND_X + 1);

  logic [CNT_W-1:0]  cand_cnt;
  logic [POS_W-1:0]  cx;
  logic [POS_W-1:0]  cy;
  logic              take;
  logic              better;
  logic signed [POS_W:0] dx;
  logic signed [POS_W:0] dy;

  assign done_cnt = (cand_cnt == CNT_W'(CAND_TOTAL));
  assign take     = en && sad_valid && (cand_cnt < CNT_W'(CAND_TOTAL));
  // strict compare: ties keep the earliest candidate in raster order
  assign better   = take && (sad_in < min_sad);
  assign dx       = $signed({1'b0, cx}) - $signed((POS_W + 1)'(RANGE));
  assign dy       = $signed({1'b0, cy}) - $signed((POS_W + 1)'(RANGE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_cnt <= '0;
      cx       <= '0;
      cy       <= '0;
      min_sad  <= '0;
      mv_x     <= '0;
      mv_y     <= '0;
    end else if (clear) begin
      cand_cnt <= '0;
      cx       <= '0;
      cy       <= '0;
      min_sad  <= '1;
      mv_x     <= '0;
      mv_y     <= '0;
    end else if (take) begin
      cand_cnt <= cand_cnt + 1'b1;
      if (cx == POS_W'(CAND_X - 1)) begin
        cx <= '0;
        cy <= cy + 1'b1;
      end else begin
        cx <= cx + 1'b1;
      end
      if (better) begin
        min_sad <= sad_in;
        mv_x    <= dx[MV_W-1:0];
        mv_y    <= dy[MV_W-1:0];
      end
    end
  end

endmodule

// File: rtl/me_search_ctrl.sv
// Motion-estimation search sequencer: loads the current macroblock, sweeps the
// search window strips and reports the full-search minimum SAD and motion vector.
//
//   state    | meaning
//   IDLE     | ready for start
//   LOAD_CUR | current-MB columns captured, addr 0..MACRO_DIM-1
//   SEARCH   | search columns shifted, addr 0..SEARCH_DIM-1 per strip amt
//   DRAIN    | waits for remaining candidate SADs
//   DONE     | one-cycle valid pulse
module me_search_ctrl
  import me_pkg::*;
#(
  parameter int MACRO_DIM  = ME_MACRO_DIM,
  parameter int SEARCH_DIM = ME_SEARCH_DIM,
  parameter int SAD_W      = ME_SAD_W,
  parameter int ADDR_W     = ME_ADDR_W,
  parameter int MV_W       = ME_MV_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              ready,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] amt,
  output logic              cpr_load,
  output logic              spr_shift,
  input  logic [SAD_W-1:0]  sad_in,
  input  logic              sad_valid,
  output logic              valid,
  output logic [SAD_W-1:0]  min_sad,
  output logic [MV_W-1:0]   mv_x,
  output logic [MV_W-1:0]   mv_y
);

  localparam int STRIPS = SEARCH_DIM / MACRO_DIM;
  localparam int CAND_X = SEARCH_DIM - MACRO_DIM + 1;
  localparam int RANGE  = (SEARCH_DIM - MACRO_DIM) / 2;

  me_state_t         state;
  me_state_t         state_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [ADDR_W-1:0] amt_nxt;
  logic              done_cnt;
  logic              trk_clear;
  logic              trk_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      addr  <= '0;
      amt   <= '0;
    end else begin
      state <= state_nxt;
      addr  <= addr_nxt;
      amt   <= amt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    amt_nxt   = amt;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_LOAD_CUR;
          addr_nxt  = '0;
          amt_nxt   = '0;
        end
      end
      ST_LOAD_CUR: begin
        if (addr == ADDR_W'(MACRO_DIM - 1)) begin
          state_nxt = ST_SEARCH;
          addr_nxt  = '0;
          amt_nxt   = '0;
        end else begin
          addr_nxt = addr + 1'b1;
        end
      end
      ST_SEARCH: begin
        if (addr == ADDR_W'(SEARCH_DIM - 1)) begin
          addr_nxt = '0;
          if (amt == ADDR_W'(STRIPS - 1)) begin
            state_nxt = ST_DRAIN;
            amt_nxt   = '0;
          end else begin
            amt_nxt = amt + 1'b1;
          end
        end else begin
          addr_nxt = addr + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (done_cnt) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
        addr_nxt  = '0;
        amt_nxt   = '0;
      end
    endcase
  end

  assign ready     = (state == ST_IDLE);
  assign valid     = (state == ST_DONE);
  assign cpr_load  = (state == ST_LOAD_CUR);
  assign spr_shift = (state == ST_SEARCH);
  assign trk_clear = ready && start;
  assign trk_en    = (state == ST_SEARCH) || (state == ST_DRAIN);

  me_best_tracker #(
    .SAD_W  (SAD_W),
    .MV_W   (MV_W),
    .CAND_X (CAND_X),
    .RANGE  (RANGE)
  ) u_tracker (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (trk_clear),
    .en        (trk_en),
    .sad_in    (sad_in),
    .sad_valid (sad_valid),
    .done_cnt  (done_cnt),
    .min_sad   (min_sad),
    .mv_x      (mv_x),
    .mv_y      (mv_y)
  );

endmodule

// File: tb/tb_me_search_ctrl.sv
// Directed bench for me_search_ctrl: address sequencing, minimum tracking,
// tie rule, extra/late SADs, ignored starts and mid-search reset.
module tb_me_search_ctrl;
  import me_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        ready;
  logic [5:0]  addr;
  logic [5:0]  amt;
  logic        cpr_load;
  logic        spr_shift;
  logic [15:0] sad_in;
  logic        sad_valid;
  logic        valid;
  logic [15:0] min_sad;
  logic [5:0]  mv_x;
  logic [5:0]  mv_y;

  int checks = 0;
  int errors = 0;

  me_search_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .ready     (ready),
    .addr      (addr),
    .amt       (amt),
    .cpr_load  (cpr_load),
    .spr_shift (spr_shift),
    .sad_in    (sad_in),
    .sad_valid (sad_valid),
    .valid     (valid),
    .min_sad   (min_sad),
    .mv_x      (mv_x),
    .mv_y      (mv_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // mode 0: flat 100; mode 1: 500 with 7 at (16,16); mode 2: 500 with 3 at (32,32)
  function automatic logic [15:0] sad_of(input int mode, input int idx);
    if (mode == 0) return 16'd100;
    if (mode == 1) return (idx == 544) ? 16'd7 : 16'd500;
    return (idx == 1088) ? 16'd3 : 16'd500;
  endfunction

  task automatic do_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_search();
    bit found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (spr_shift) found = 1;
      @(posedge clk); #1;
    end
    check("search_reached", int'(found), 1);
  endtask

  task automatic feed(input int mode, input bit gap, input bit extras, input bit probe_start,
                      input int exp_sad, input int exp_x, input int exp_y, input string tag);
    int nvalid = 0;
    int first_k = -1;
    for (int i = 0; i < NCAND; i++) begin
      sad_valid = 1'b1;
      sad_in    = sad_of(mode, i);
      @(posedge clk); #1;
      if (gap && i < NCAND - 1) begin
        sad_valid = 1'b0;
        sad_in    = 16'hdead;
        @(posedge clk); #1;
      end
    end
    for (int k = 0; k < 10; k++) begin
      sad_valid = extras && (k < 5);
      sad_in    = 16'd0;
      start     = probe_start && (k == 1);
      @(negedge clk);
      if (valid) begin
        nvalid++;
        if (first_k < 0) first_k = k;
      end
      if (probe_start && k == 3) begin
        check({tag, "_done_start_ready"}, int'(ready), 1);
        check({tag, "_done_start_noload"}, int'(cpr_load), 0);
      end
      @(posedge clk); #1;
    end
    sad_valid = 1'b0;
    start     = 1'b0;
    check({tag, "_valid_count"}, nvalid, 1);
    check({tag, "_valid_latency"}, first_k, 1);
    check({tag, "_min_sad"}, int'(min_sad), exp_sad);
    check({tag, "_mv_x"}, int'($signed(mv_x)), exp_x);
    check({tag, "_mv_y"}, int'($signed(mv_y)), exp_y);
  endtask

  initial begin
    int nvalid;
    rst_n     = 1'b0;
    start     = 1'b0;
    sad_valid = 1'b0;
    sad_in    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", int'(ready), 1);
    check("rst_valid", int'(valid), 0);
    check("rst_addr", int'(addr), 0);
    check("rst_amt", int'(amt), 0);
    check("rst_min_sad", int'(min_sad), 0);
    check("rst_mv_x", int'(mv_x), 0);
    check("rst_mv_y", int'(mv_y), 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // address sequencing, then tie rule with flat SADs fed during DRAIN
    do_start();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("load_cpr", int'(cpr_load), 1);
      check("load_addr", int'(addr), i);
      check("load_amt", int'(amt), 0);
      check("load_ready", int'(ready), 0);
      @(posedge clk);
    end
    for (int s = 0; s < 144; s++) begin
      @(negedge clk);
      check("srch_shift", int'(spr_shift), 1);
      check("srch_cpr", int'(cpr_load), 0);
      check("srch_addr", int'(addr), s % 48);
      check("srch_amt", int'(amt), s / 48);
      check("srch_ready", int'(ready), 0);
      @(posedge clk);
    end
    @(negedge clk);
    check("drain_shift", int'(spr_shift), 0);
    check("drain_addr", int'(addr), 0);
    check("drain_amt", int'(amt), 0);
    check("drain_ready", int'(ready), 0);
    check("drain_valid", int'(valid), 0);
    @(posedge clk); #1;
    feed(0, 0, 0, 0, 100, -16, -16, "flat");

    do_start();
    wait_search();
    feed(1, 0, 0, 1, 7, 0, 0, "centre");

    do_start();
    wait_search();
    feed(2, 0, 0, 0, 3, 16, 16, "corner");

    do_start();
    wait_search();
    feed(1, 1, 1, 0, 7, 0, 0, "gapped");

    // start during SEARCH ignored, then reset mid-search
    do_start();
    wait_search();
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("busy_start_ready", int'(ready), 0);
    check("busy_start_shift", int'(spr_shift), 1);
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) begin
      sad_valid = 1'b1;
      sad_in    = 16'd1;
      @(posedge clk); #1;
    end
    sad_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("abort_ready", int'(ready), 1);
    check("abort_addr", int'(addr), 0);
    check("abort_shift", int'(spr_shift), 0);
    check("abort_min_sad", int'(min_sad), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    nvalid = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (valid) nvalid++;
    end
    check("abort_no_valid", nvalid, 0);
    @(posedge clk); #1;
    do_start();
    wait_search();
    feed(1, 0, 0, 0, 7, 0, 0, "rerun");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
